// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant,
// binary grant index and a hold limit that forces re-arbitration.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_grant;
    logic [7:0]       w_grant_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [2:0]       r_ptr;
    logic [2:0]       w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_tmo;
    logic             w_tmo_nxt;
    logic             w_award;
    logic             w_any;
    logic [2:0]       w_win;

    // Scan p+1, p+2, ... wrapping; p itself has lowest priority.
    function automatic logic [2:0] f_pick(
        input logic [7:0] v,
        input logic [2:0] p
    );
        logic [2:0] r;
        logic [2:0] c;
        r = p;
        for (int i = 8; i >= 1; i--) begin
            c = p + 3'(i);
            if (v[c]) r = c;
        end
        return r;
    endfunction

    assign w_any = |req;
    assign w_win = f_pick(req, r_ptr);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = 1'b0;
        w_award     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) w_award = 1'b1;
            end
            S_GRANT: begin
                if (!req[r_idx]) begin
                    if (w_any) begin
                        w_award = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_grant_nxt = 8'h00;
                        w_cnt_nxt   = '0;
                    end
                end else if (r_cnt < CNT_W'(MAX_HOLD - 1)) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    w_tmo_nxt = 1'b1;
                    w_award   = 1'b1;
                end
            end
        endcase
        if (w_award) begin
            w_state_nxt = S_GRANT;
            w_grant_nxt = 8'h01 << w_win;
            w_idx_nxt   = w_win;
            w_ptr_nxt   = w_win;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= 8'h00;
            r_idx   <= 3'd0;
            r_ptr   <= 3'd7;
            r_cnt   <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_idx;
    assign busy      = (r_state == S_GRANT);
    assign timeout   = r_tmo;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: a reference model pushes expected
// outputs per clock edge, a negedge monitor pops and compares.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 16;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    logic [12:0] exp_q[$];

    int m_owner;
    int m_ptr;
    int m_idx;
    int m_age;
    bit m_tmo;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .grant_idx(grant_idx),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 1; k <= 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 7;
        m_idx   = 0;
        m_age   = 0;
        m_tmo   = 0;
    endtask

    // m_age = number of cycles the current award has already been visible
    task automatic model_step(input logic [7:0] r);
        int w;
        w = -1;
        m_tmo = 0;
        if (m_owner < 0) begin
            if (r != 0) w = pick(r, m_ptr);
        end else if (!r[m_owner]) begin
            if (r != 0) w = pick(r, m_ptr);
            else m_owner = -1;
        end else if (m_age + 1 < MAX_HOLD) begin
            m_age++;
        end else begin
            m_tmo = 1;
            w = pick(r, m_owner);
        end
        if (w >= 0) begin
            m_owner = w;
            m_ptr   = w;
            m_idx   = w;
            m_age   = 0;
        end
    endtask

    function automatic logic [12:0] model_out();
        logic [7:0] g;
        g = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        return {g, 3'(m_idx), (m_owner >= 0), m_tmo};
    endfunction

    task automatic cyc(input logic [7:0] r);
        req = r;
        @(posedge clk);
        #1;
        model_step(r);
        exp_q.push_back(model_out());
    endtask

    task automatic direct(input string nm, input logic [12:0] e);
        checks++;
        if ({grant, grant_idx, busy, timeout} !== e) begin
            failures++;
            $display("FAIL %s: got g=%h i=%0d b=%b t=%b want g=%h i=%0d b=%b t=%b",
                     nm, grant, grant_idx, busy, timeout,
                     e[12:5], e[4:2], e[1], e[0]);
        end
    endtask

    always @(negedge clk) begin
        logic [12:0] e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({grant, grant_idx, busy, timeout} !== e) begin
                failures++;
                $display("FAIL out @%0t: got g=%h i=%0d b=%b t=%b want g=%h i=%0d b=%b t=%b",
                         $time, grant, grant_idx, busy, timeout,
                         e[12:5], e[4:2], e[1], e[0]);
            end
        end
    end

    initial begin
        logic [7:0] r;
        rst = 1'b1;
        req = 8'h00;
        model_reset();
        #2;
        direct("reset_async", 13'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        repeat (5) cyc(8'h00);

        cyc(8'h05);
        cyc(8'h04);
        cyc(8'h00);

        for (int n = 0; n < 20; n++) begin
            r = 8'hFF;
            if (m_owner >= 0 && m_age == 1) r[m_owner] = 1'b0;
            cyc(r);
        end
        cyc(8'h00);

        repeat (40) cyc(8'h08);
        repeat (40) cyc(8'h28);
        cyc(8'h00);

        repeat (3) cyc(8'h10);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        direct("reset_midgrant", 13'h0);
        model_reset();
        #1;
        rst = 1'b0;
        cyc(8'h90);
        cyc(8'h80);
        cyc(8'h00);

        repeat (2) cyc(8'h40);
        cyc(8'h82);
        cyc(8'h02);
        cyc(8'h00);

        for (int n = 0; n < 400; n++) begin
            r = 8'($urandom);
            if (m_owner >= 0 && $urandom_range(7) != 0) r[m_owner] = 1'b1;
            if ($urandom_range(15) == 0) r = 8'h00;
            cyc(r);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
